// File: rtl/dmem_arb_pkg.sv
// Shared defaults, index-width helper and the read-return tag carried alongside memory commands.
package dmem_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 15;
   localparam int MAX_REQ     = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W     = idx_w(DEF_NUM_REQ);
   // Tag index is sized for the largest legal requester count so every instance shares one type.
   localparam int TAG_IDX_W = idx_w(MAX_REQ);

   typedef struct packed {
      logic                 valid;
      logic                 is_read;
      logic [TAG_IDX_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr wins, wrapping to 0.
// Emits a one-hot grant and the binary winner index (index is 0 when nothing requests).
module rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int IW = IDX_W
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic w_found;
   int   w_pos;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int i = 0; i < N; i++) begin
         w_pos = int'(i_ptr) + i;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end
         if (!w_found && i_req[w_pos]) begin
            w_found      = 1'b1;
            o_gnt[w_pos] = 1'b1;
            o_idx        = IW'(w_pos);
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one BlockRAM port; registered command stage, reads return 2 cycles after acceptance.
// A tag pipeline alongside the command steers the one-hot read-valid pulse back to the original requester.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int data_width = DEF_DATA_W,
   parameter int addr_width = DEF_ADDR_W
) (
   input  logic                          i_CLK,
   input  logic                          i_RST,
   input  logic [NUM_REQ-1:0]            i_REQ,
   input  logic [NUM_REQ-1:0]            i_WE,
   input  logic [NUM_REQ*addr_width-1:0] i_ADDR,
   input  logic [NUM_REQ*data_width-1:0] i_WDATA,
   output logic [NUM_REQ-1:0]            o_GNT,
   output logic [NUM_REQ-1:0]            o_RVALID,
   output logic [data_width-1:0]         o_RDATA,
   output logic                          o_MEM_EN,
   output logic                          o_MEM_WE,
   output logic [addr_width-1:0]         o_MEM_ADDR,
   output logic [data_width-1:0]         o_MEM_WDATA,
   input  logic [data_width-1:0]         i_MEM_RDATA
);

   localparam int IW = idx_w(NUM_REQ);

   logic [IW-1:0]         r_ptr;
   tag_t                  r_tag1;
   tag_t                  r_tag2;

   logic [NUM_REQ-1:0]    w_pick_gnt;
   logic [IW-1:0]         w_win;
   logic [IW-1:0]         w_ptr_nxt;
   logic                  w_acc;
   logic                  w_win_we;
   logic [addr_width-1:0] w_win_addr;
   logic [data_width-1:0] w_win_wdata;
   tag_t                  w_tag_in;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .i_req (i_REQ),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_win)
   );

   assign o_GNT       = i_RST ? '0 : w_pick_gnt;
   assign w_acc       = |(i_REQ & o_GNT);
   assign w_win_we    = i_WE[w_win];
   assign w_win_addr  = i_ADDR[w_win*addr_width +: addr_width];
   assign w_win_wdata = i_WDATA[w_win*data_width +: data_width];
   assign w_ptr_nxt   = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

   always_comb begin
      w_tag_in         = '0;
      w_tag_in.valid   = w_acc;
      w_tag_in.is_read = ~w_win_we;
      w_tag_in.idx     = TAG_IDX_W'(w_win);
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_ptr       <= '0;
         o_MEM_EN    <= 1'b0;
         o_MEM_WE    <= 1'b0;
         o_MEM_ADDR  <= '0;
         o_MEM_WDATA <= '0;
         r_tag1      <= '0;
         r_tag2      <= '0;
      end else begin
         o_MEM_EN <= w_acc;
         o_MEM_WE <= w_acc & w_win_we;
         if (w_acc) begin
            r_ptr       <= w_ptr_nxt;
            o_MEM_ADDR  <= w_win_addr;
            o_MEM_WDATA <= w_win_wdata;
         end
         r_tag1 <= w_tag_in;
         r_tag2 <= r_tag1;
      end
   end

   // Second tag stage lines up with the cycle the BlockRAM presents read data.
   always_comb begin
      o_RVALID = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r_tag2.valid && r_tag2.is_read && (r_tag2.idx == TAG_IDX_W'(k))) begin
            o_RVALID[k] = 1'b1;
         end
      end
   end

   assign o_RDATA = i_MEM_RDATA;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-first single-port memory model.
module tb_dmem_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   we;
   logic [59:0]  addr;
   logic [127:0] wdata;
   logic [3:0]   gnt;
   logic [3:0]   rvalid;
   logic [31:0]  rdata;
   logic         mem_en;
   logic         mem_we;
   logic [14:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;

   logic [31:0]  mem [0:32767];
   logic         pl_en;
   logic [14:0]  pl_addr;
   logic [31:0]  pl_dat;

   int checks;
   int failures;

   dmem_arbiter #(
      .NUM_REQ    (4),
      .data_width (32),
      .addr_width (15)
   ) dut (
      .i_CLK       (clk),
      .i_RST       (rst),
      .i_REQ       (req),
      .i_WE        (we),
      .i_ADDR      (addr),
      .i_WDATA     (wdata),
      .o_GNT       (gnt),
      .o_RVALID    (rvalid),
      .o_RDATA     (rdata),
      .o_MEM_EN    (mem_en),
      .o_MEM_WE    (mem_we),
      .o_MEM_ADDR  (mem_addr),
      .o_MEM_WDATA (mem_wdata),
      .i_MEM_RDATA (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first synchronous memory with a bench-side preload port.
   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_dat;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic w, input logic [14:0] a, input logic [31:0] d);
      we[k]             = w;
      addr[k*15 +: 15]  = a;
      wdata[k*32 +: 32] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      we  = 4'b0000;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
         failures++;
         $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000);
      end
      checks++;
      if (mem_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_mem_en got=%b exp=%b", mem_en, 1'b0);
      end
      checks++;
      if (rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL reset_rvalid got=%b exp=%b", rvalid, 4'b0000);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL reset_first_gnt got=%b exp=%b", gnt, 4'b0001);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_single_read();
      pl_en   = 1'b1;
      pl_addr = 15'h0010;
      pl_dat  = 32'hDEADBEEF;
      tick();
      pl_en = 1'b0;
      drive(2, 1'b0, 15'h0010, 32'h0);
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL rd_gnt got=%b exp=%b", gnt, 4'b0100);
      end
      tick();
      req = 4'b0000;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 15'h0010) begin
         failures++;
         $display("FAIL rd_cmd got=en%b we%b a%h exp=en1 we0 a0010", mem_en, mem_we, mem_addr);
      end
      checks++;
      if (rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL rd_early_rvalid got=%b exp=%b", rvalid, 4'b0000);
      end
      tick();
      checks++;
      if (rvalid !== 4'b0100) begin
         failures++;
         $display("FAIL rd_rvalid got=%b exp=%b", rvalid, 4'b0100);
      end
      checks++;
      if (rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rd_data got=%h exp=%h", rdata, 32'hDEADBEEF);
      end
      tick();
   endtask

   task automatic test_write_read();
      drive(1, 1'b1, 15'h7FFF, 32'h12345678);
      req = 4'b0010;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL wr_gnt got=%b exp=%b", gnt, 4'b0010);
      end
      tick();
      drive(1, 1'b0, 15'h7FFF, 32'h0);
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL wr_rd_gnt got=%b exp=%b", gnt, 4'b0010);
      end
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 15'h7FFF || mem_wdata !== 32'h12345678) begin
         failures++;
         $display("FAIL wr_cmd got=we%b a%h d%h exp=we1 a7fff d12345678", mem_we, mem_addr, mem_wdata);
      end
      tick();
      req = 4'b0000;
      checks++;
      if (rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL wr_no_rvalid got=%b exp=%b", rvalid, 4'b0000);
      end
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL wr_rd_cmd got=en%b we%b exp=en1 we0", mem_en, mem_we);
      end
      tick();
      checks++;
      if (rvalid !== 4'b0010 || rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL wr_rd_data got=%b/%h exp=0010/12345678", rvalid, rdata);
      end
      tick();
   endtask

   task automatic test_fairness();
      logic [3:0] one;
      logic [3:0] exp_g;
      logic [3:0] exp_v;
      one = 4'b0001;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) drive(k, 1'b0, 15'(k + 32), 32'h0);
      req = 4'b1111;
      for (int c = 0; c < 18; c++) begin
         if (c == 16) req = 4'b0000;
         #1;
         exp_g = one << (c % 4);
         exp_v = (c >= 2) ? (one << ((c - 2) % 4)) : 4'b0000;
         if (c < 16) begin
            checks++;
            if (gnt !== exp_g) begin
               failures++;
               $display("FAIL fair_gnt c=%0d got=%b exp=%b", c, gnt, exp_g);
            end
         end
         checks++;
         if (rvalid !== exp_v) begin
            failures++;
            $display("FAIL fair_rvalid c=%0d got=%b exp=%b", c, rvalid, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_wrap_skip();
      logic [3:0] exp_seq [3];
      exp_seq[0] = 4'b0001;
      exp_seq[1] = 4'b0100;
      exp_seq[2] = 4'b0001;
      drive(0, 1'b0, 15'h0001, 32'h0);
      drive(2, 1'b0, 15'h0002, 32'h0);
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL wrap_setup got=%b exp=%b", gnt, 4'b0100);
      end
      tick();
      req = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (gnt !== exp_seq[i]) begin
            failures++;
            $display("FAIL wrap_gnt i=%0d got=%b exp=%b", i, gnt, exp_seq[i]);
         end
         if (i == 2) req = 4'b0000;
         tick();
      end
      tick();
      tick();
   endtask

   task automatic test_reset_midflight();
      drive(1, 1'b0, 15'h0003, 32'h0);
      req = 4'b0010;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL mid_gnt0 got=%b exp=%b", gnt, 4'b0010);
      end
      tick();
      drive(2, 1'b0, 15'h0004, 32'h0);
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL mid_gnt1 got=%b exp=%b", gnt, 4'b0100);
      end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000 || mem_en !== 1'b0 || rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL mid_in_reset got=g%b en%b v%b exp=g0000 en0 v0000", gnt, mem_en, rvalid);
      end
      req = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL mid_stale_rvalid c=%0d got=%b exp=%b", c, rvalid, 4'b0000);
         end
         tick();
      end
      req = 4'b1111;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL mid_ptr_gnt got=%b exp=%b", gnt, 4'b0001);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      we       = 4'b0000;
      addr     = '0;
      wdata    = '0;
      pl_en    = 1'b0;
      pl_addr  = '0;
      pl_dat   = '0;
      test_reset();
      test_single_read();
      test_write_read();
      test_fairness();
      test_wrap_skip();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
